noc_port_arbiter: RTL and testbench

Round-robin arbiter for one router output port. Up to five input directions (N, E, S, W, Local) request the same output link. The block grants one requester per cycle and captures the winning 33-bit packet into a single-entry output register with a valid/ready handshake. One instance sits in front of each router output (O1–O5) and serialises contending packets fairly.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_rr_pick.sv | 43 ++++
 rtl/noc_port_arbiter.sv | 72 +++++++
 tb/tb_noc_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared router constants: packet geometry, requester count, direction
// encoding and a small index helper used by the port arbiters.
package noc_pkg;

    localparam int WIDTH = 33;
    localparam int NREQ  = 5;

    // Packet field positions, shared with the switch.
    localparam int TYPE_BIT  = WIDTH - 1;
    localparam int DEST_X_HI = WIDTH - 2;
    localparam int DEST_X_LO = WIDTH - 3;
    localparam int DEST_Y_HI = WIDTH - 4;
    localparam int DEST_Y_LO = WIDTH - 5;

    // Requester index doubles as the input direction code.
    typedef enum logic [2:0] {
        N     = 3'd0,
        E     = 3'd1,
        S     = 3'd2,
        W     = 3'd3,
        LOCAL = 3'd4
    } dir_t;

    // Next requester index after idx, wrapping NREQ-1 back to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= 3'(NREQ - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward with wrap-around. Out-of-range ptr values search from 0.
module noc_rr_pick
    import noc_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            any
);

    logic [2:0] start;
    logic [3:0] sum;
    logic [2:0] cand;
    logic       found;

    // Rotating priority search over the request vector.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        any   = |req;
        start = (ptr < 3'(NREQ)) ? ptr : 3'd0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, start} + 4'(off);
            if (sum >= 4'(NREQ)) begin
                sum = sum - 4'(NREQ);
            end
            cand = sum[2:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Output-port arbiter: grants one of NREQ requesters per cycle in
// round-robin order and holds the winning packet in a single-entry
// valid/ready output register.
module noc_port_arbiter
    import noc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         in_valid,
    input  logic [NREQ*WIDTH-1:0]   in_data,
    output logic [NREQ-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [2:0]              out_src,
    input  logic                    out_ready,
    output logic [2:0]              ptr
);

    logic [NREQ-1:0]  pick_gnt;
    logic [2:0]       pick_idx;
    logic             pick_any;
    logic             can_accept;
    logic             grant;
    logic [WIDTH-1:0] sel_data;

    noc_rr_pick u_pick (
        .req (in_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The register can take a packet when empty or draining this cycle;
    // reset holds all grants low so nothing is consumed while asserted.
    always_comb begin
        can_accept = !out_valid || out_ready;
        grant      = rst_n && can_accept && pick_any;
        in_ready   = grant ? pick_gnt : '0;
    end

    // One-hot AND-OR mux of the granted packet; the packet is not altered.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{pick_gnt[i]}});
        end
    end

    // Output register and priority pointer; fill wins over drain so a
    // same-edge drain and fill keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset as well, so a dropped packet
            // never reappears and out_data reads 0 straight out of reset.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (grant) begin
            // NOTE: non-blocking assignments keep every register updating
            // from pre-edge values, independent of statement order.
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= pick_idx;
            ptr       <= next_idx(pick_idx);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model of the arbiter.
module tb_noc_port_arbiter;
    import noc_pkg::WIDTH;
    import noc_pkg::NREQ;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       in_valid = '0;
    logic [NREQ*WIDTH-1:0] in_data = '0;
    logic [NREQ-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [2:0]            out_src;
    logic                  out_ready = 1'b0;
    logic [2:0]            ptr;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    noc_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_ptr;

    // First valid requester scanning ptr, ptr+1, ... modulo NREQ; -1 if none.
    function automatic int model_pick();
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (in_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int p;
        r = '0;
        if (rst_n !== 1'b1) return r;
        if (m_valid && !out_ready) return r;
        p = model_pick();
        if (p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] model_pkt(input int k);
        return in_data[k*WIDTH +: WIDTH];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= 0;
        end else if (model_ready() != '0) begin
            m_valid <= 1'b1;
            m_data  <= model_pkt(model_pick());
            m_src   <= model_pick();
            m_ptr   <= (model_pick() + 1) % NREQ;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare DUT against model mid-cycle, with inputs settled.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_in_ready",  64'(in_ready),  64'(model_ready()));
            check("model_out_valid", 64'(out_valid), 64'(m_valid));
            check("model_out_data",  64'(out_data),  64'(m_data));
            check("model_out_src",   64'(out_src),   64'(m_src));
            check("model_ptr",       64'(ptr),       64'(m_ptr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [WIDTH-1:0] d);
        in_data[i*WIDTH +: WIDTH] = d;
    endtask

    localparam logic [WIDTH-1:0] PKT_S = 33'h1_2345_6789;

    int exp_order [7] = '{0, 1, 2, 3, 4, 0, 1};
    int exp_ptr   [7] = '{1, 2, 3, 4, 0, 1, 2};
    logic [WIDTH-1:0] held;
    logic [NREQ-1:0]  g;
    logic [NREQ-1:0]  pending;

    initial begin
        // ---- 1. reset / idle ----
        #12;
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        set_pkt(0, 33'h0_dead_beef);
        in_valid  = 5'b00001;
        out_ready = 1'b0;
        tick();
        in_valid = '0;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_src",   64'(out_src),   64'd0);
        check("rst_ptr",       64'(ptr),       64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_ptr",      64'(ptr),      64'd0);

        // ---- 2. single requester S ----
        set_pkt(2, PKT_S);
        in_valid = 5'b00100;
        #1;
        check("single_in_ready", 64'(in_ready), 64'b00100);
        tick();
        in_valid = '0;
        #1;
        check("single_in_ready_off", 64'(in_ready),  64'd0);
        check("single_out_valid",    64'(out_valid), 64'd1);
        check("single_out_data",     64'(out_data),  64'(PKT_S));
        check("single_out_src",      64'(out_src),   64'd2);
        check("single_ptr",          64'(ptr),       64'd3);

        // ---- 5. priority skip: ptr=3, requesters 0 and 1 ----
        set_pkt(0, 33'h0_0000_0a00);
        set_pkt(1, 33'h0_0000_0a01);
        in_valid = 5'b00011;
        #1;
        check("skip_in_ready", 64'(in_ready), 64'b00001);
        tick();
        in_valid = '0;
        check("skip_out_src", 64'(out_src), 64'd0);
        check("skip_ptr",     64'(ptr),     64'd1);

        // Bring ptr back to 0 via requester 4.
        set_pkt(4, 33'h1_0000_0004);
        in_valid = 5'b10000;
        tick();
        in_valid = '0;
        check("wrap4_ptr", 64'(ptr), 64'd0);

        // ---- 3. round-robin wrap with all requesters valid ----
        for (int i = 0; i < NREQ; i++) set_pkt(i, 33'(32'hA000_0000 + i));
        in_valid = 5'b11111;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("rr_grant", 64'(in_ready), 64'(5'b00001 << exp_order[i]));
            tick();
            check("rr_ptr", 64'(ptr), 64'(exp_ptr[i]));
        end

        // ---- 4. backpressure with everyone requesting ----
        held = out_data;
        check("bp_held_src", 64'(out_src), 64'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_out_data",  64'(out_data),  64'(33'hA000_0001));
            check("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("bp_held_data", 64'(out_data), 64'(held));
        out_ready = 1'b1;
        #1;
        check("bp_release_grant", 64'(in_ready), 64'b00100);
        tick();
        check("bp_drain_fill_valid", 64'(out_valid), 64'd1);
        check("bp_drain_fill_src",   64'(out_src),   64'd2);
        check("bp_drain_fill_ptr",   64'(ptr),       64'd3);

        // ---- 6. late arrival of a higher-priority requester ----
        in_valid = 5'b00001;
        set_pkt(0, 33'h0_0000_0b00);
        tick();
        check("late_setup_ptr", 64'(ptr), 64'd1);
        set_pkt(4, 33'h1_0000_0b04);
        set_pkt(1, 33'h0_0000_0b01);
        in_valid  = 5'b10000;
        out_ready = 1'b0;
        tick();
        in_valid = 5'b10010;
        #1;
        check("late_blocked", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        #1;
        check("late_first_grant", 64'(in_ready), 64'b00010);
        tick();
        in_valid = 5'b10000;
        check("late_first_src", 64'(out_src), 64'd1);
        #1;
        check("late_second_grant", 64'(in_ready), 64'b10000);
        tick();
        in_valid = '0;
        check("late_second_src",  64'(out_src),  64'd4);
        check("late_second_data", 64'(out_data), 64'(33'h1_0000_0b04));
        check("late_second_ptr",  64'(ptr),      64'd0);

        // ---- randomized traffic, checked by the model every cycle ----
        pending = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && ($urandom_range(0, 2) == 0)) begin
                    pending[i] = 1'b1;
                    set_pkt(i, {1'($urandom), 32'($urandom)});
                end
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = in_ready;
            @(posedge clk);
            #1;
            pending = pending & ~g;
            if (cyc == 1000 || cyc == 2000) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rand_rst_out_valid", 64'(out_valid), 64'd0);
                check("rand_rst_ptr",       64'(ptr),       64'd0);
                #1;
                rst_n = 1'b1;
            end
        end

        in_valid = '0;
        chk_en   = 1'b0;
        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
